// File: rtl/axi4_id_remapper_pkg.sv
// axi4_id_remapper_pkg: slot geometry helpers and the allocation-table slot record
package axi4_id_remapper_pkg;
  // Widest inbound id and outstanding counter a slot record can hold.
  localparam int MAX_IN_ID_W = 32;
  localparam int MAX_CNT_W = 8;
  function automatic int nslot(input int out_id_w);
    return 1 << out_id_w;
  endfunction
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction
  typedef struct packed {
    logic valid;
    logic [MAX_IN_ID_W-1:0] in_id;
    logic [MAX_CNT_W-1:0] cnt;
  } slot_t;
endpackage

// File: rtl/axi4_id_remap_table.sv
// axi4_id_remap_table: one direction's id allocation table (lookup, allocate on request, release on response)
module axi4_id_remap_table
  import axi4_id_remapper_pkg::*;
#(
  parameter int IN_ID_W = 8,
  parameter int OUT_ID_W = 2,
  parameter int MAX_OUT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  input  logic req_ready,
  input  logic [IN_ID_W-1:0] req_id,
  output logic blocked,
  output logic [OUT_ID_W-1:0] alloc_idx,
  input  logic rel,
  input  logic [OUT_ID_W-1:0] rsp_idx,
  output logic [IN_ID_W-1:0] rsp_in_id,
  output logic busy
);
  localparam int NSLOT = nslot(OUT_ID_W);
  localparam int CW = cnt_w(MAX_OUT);
  localparam logic [MAX_CNT_W-1:0] FULL = MAX_CNT_W'(MAX_OUT);
  if (CW > MAX_CNT_W || IN_ID_W > MAX_IN_ID_W) begin : g_width_chk
    $error("axi4_id_remap_table: id or counter wider than the slot record");
  end
  slot_t tbl [NSLOT];
  logic hit, free, alloc;
  logic [OUT_ID_W-1:0] hit_idx, free_idx;
  // Find the slot already mapping this id, else the lowest free slot (descending scan so lowest wins).
  always_comb begin
    hit = 1'b0;
    free = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    busy = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].in_id == MAX_IN_ID_W'(req_id)) begin
        hit = 1'b1;
        hit_idx = OUT_ID_W'(i);
      end
      if (!tbl[i].valid) begin
        free = 1'b1;
        free_idx = OUT_ID_W'(i);
      end
      busy = busy | tbl[i].valid;
    end
  end
  assign blocked = hit ? tbl[hit_idx].cnt == FULL : !free;
  assign alloc_idx = hit ? hit_idx : free_idx;
  assign alloc = req_valid & req_ready & !blocked;
  assign rsp_in_id = tbl[rsp_idx].in_id[IN_ID_W-1:0];
  // Count allocations up and releases down; a same-cycle pair cancels, a release at zero is ignored.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NSLOT; i++) begin
      if (reset) begin
        tbl[i] <= '0;
      end else if (alloc && alloc_idx == OUT_ID_W'(i)) begin
        tbl[i].valid <= 1'b1;
        tbl[i].in_id <= MAX_IN_ID_W'(req_id);
        tbl[i].cnt <= (rel && rsp_idx == OUT_ID_W'(i)) ? (tbl[i].cnt == '0 ? MAX_CNT_W'(1) : tbl[i].cnt)
                                                       : tbl[i].cnt + MAX_CNT_W'(1);
      end else if (rel && rsp_idx == OUT_ID_W'(i)) begin
        tbl[i].valid <= tbl[i].cnt > MAX_CNT_W'(1);
        tbl[i].cnt <= tbl[i].cnt == '0 ? '0 : tbl[i].cnt - MAX_CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/axi4_id_remapper.sv
// axi4_id_remapper: squeezes wide AXI4 ids onto a small outbound id pool; AXI4_ID_REMAPPER_PERF_EN adds stall counters
module axi4_id_remapper
  import axi4_id_remapper_pkg::*;
#(
  parameter int IN_ID_W = 8,
  parameter int OUT_ID_W = 2,
  parameter int MAX_OUT = 8,
  parameter int AX_PAY_W = 53,
  parameter int W_PAY_W = 73,
  parameter int R_PAY_W = 66
) (
  input  logic clock,
  input  logic reset,
  input  logic in_aw_valid,
  output logic in_aw_ready,
  input  logic [IN_ID_W-1:0] in_aw_id,
  input  logic [AX_PAY_W-1:0] in_aw_pay,
  input  logic in_w_valid,
  output logic in_w_ready,
  input  logic [W_PAY_W-1:0] in_w_pay,
  output logic in_b_valid,
  input  logic in_b_ready,
  output logic [IN_ID_W-1:0] in_b_id,
  output logic [1:0] in_b_resp,
  input  logic in_ar_valid,
  output logic in_ar_ready,
  input  logic [IN_ID_W-1:0] in_ar_id,
  input  logic [AX_PAY_W-1:0] in_ar_pay,
  output logic in_r_valid,
  input  logic in_r_ready,
  output logic [IN_ID_W-1:0] in_r_id,
  output logic [R_PAY_W-1:0] in_r_pay,
  output logic in_r_last,
  output logic out_aw_valid,
  input  logic out_aw_ready,
  output logic [OUT_ID_W-1:0] out_aw_id,
  output logic [AX_PAY_W-1:0] out_aw_pay,
  output logic out_w_valid,
  input  logic out_w_ready,
  output logic [W_PAY_W-1:0] out_w_pay,
  input  logic out_b_valid,
  output logic out_b_ready,
  input  logic [OUT_ID_W-1:0] out_b_id,
  input  logic [1:0] out_b_resp,
  output logic out_ar_valid,
  input  logic out_ar_ready,
  output logic [OUT_ID_W-1:0] out_ar_id,
  output logic [AX_PAY_W-1:0] out_ar_pay,
  input  logic out_r_valid,
  output logic out_r_ready,
  input  logic [OUT_ID_W-1:0] out_r_id,
  input  logic [R_PAY_W-1:0] out_r_pay,
  input  logic out_r_last,
  output logic busy
`ifdef AXI4_ID_REMAPPER_PERF_EN
  ,
  output logic [31:0] aw_stall_cnt,
  output logic [31:0] ar_stall_cnt
`endif
);
  logic aw_blk, ar_blk, w_busy, r_busy;
  axi4_id_remap_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)) u_wr (
    .clock(clock), .reset(reset),
    .req_valid(in_aw_valid), .req_ready(out_aw_ready), .req_id(in_aw_id),
    .blocked(aw_blk), .alloc_idx(out_aw_id),
    .rel(out_b_valid & in_b_ready), .rsp_idx(out_b_id), .rsp_in_id(in_b_id),
    .busy(w_busy)
  );
  axi4_id_remap_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)) u_rd (
    .clock(clock), .reset(reset),
    .req_valid(in_ar_valid), .req_ready(out_ar_ready), .req_id(in_ar_id),
    .blocked(ar_blk), .alloc_idx(out_ar_id),
    .rel(out_r_valid & in_r_ready & out_r_last), .rsp_idx(out_r_id), .rsp_in_id(in_r_id),
    .busy(r_busy)
  );
  assign out_aw_valid = in_aw_valid & !aw_blk;
  assign in_aw_ready = out_aw_ready & !aw_blk;
  assign out_aw_pay = in_aw_pay;
  assign out_ar_valid = in_ar_valid & !ar_blk;
  assign in_ar_ready = out_ar_ready & !ar_blk;
  assign out_ar_pay = in_ar_pay;
  assign out_w_valid = in_w_valid;
  assign in_w_ready = out_w_ready;
  assign out_w_pay = in_w_pay;
  assign in_b_valid = out_b_valid;
  assign out_b_ready = in_b_ready;
  assign in_b_resp = out_b_resp;
  assign in_r_valid = out_r_valid;
  assign out_r_ready = in_r_ready;
  assign in_r_pay = out_r_pay;
  assign in_r_last = out_r_last;
  assign busy = w_busy | r_busy;
`ifdef AXI4_ID_REMAPPER_PERF_EN
  // Saturating counts of cycles where a request is presented but held off by the table.
  always_ff @(posedge clock) begin
    if (reset) begin
      aw_stall_cnt <= '0;
      ar_stall_cnt <= '0;
    end else begin
      aw_stall_cnt <= aw_stall_cnt + 32'(in_aw_valid & aw_blk & ~&aw_stall_cnt);
      ar_stall_cnt <= ar_stall_cnt + 32'(in_ar_valid & ar_blk & ~&ar_stall_cnt);
    end
  end
`endif
endmodule

// File: doc/axi4_id_remapper.md
Name: axi4_id_remapper

Overview:
- Parametrised successor to the stateless AXI4 ID indexer.
- Compresses a wide inbound AXI4 ID space (IN_ID_W bits) onto a small pool of 2^OUT_ID_W outbound IDs per direction, using an allocation table with per-slot outstanding counters.
- Responses are restored to the original inbound ID from the table.
- Sits between the crossbar-side master port and a narrow-ID slave, e.g. a memory port.

Parameters:
IN_ID_W, 8, inbound ID width
OUT_ID_W, 2, outbound ID width; slot count NSLOT = 2^OUT_ID_W per direction
MAX_OUT, 8, max outstanding transactions per slot (counter width clog2(MAX_OUT+1))
AX_PAY_W, 53, AW/AR payload width (addr, len, size, burst, cache, prot), passed through untouched
W_PAY_W, 73, W payload width (data, strb, last)
R_PAY_W, 66, R payload width excluding id (data, resp); last is a separate port

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
in_aw_valid/in_aw_ready  in/out  1  inbound AW handshake
in_aw_id  in  IN_ID_W  inbound AW id
in_aw_pay  in  AX_PAY_W  AW payload
in_w_valid/in_w_ready  in/out  1  W handshake, pure pass-through
in_w_pay  in  W_PAY_W  W payload
in_b_valid/in_b_ready  out/in  1  B handshake
in_b_id  out  IN_ID_W  restored B id
in_b_resp  out  2  B resp
in_ar_valid/in_ar_ready, in_ar_id, in_ar_pay  as AW
in_r_valid/in_r_ready  out/in  1  R handshake
in_r_id  out  IN_ID_W  restored R id
in_r_pay  out  R_PAY_W  R payload
in_r_last  out  1  R last
out_* mirror of all of the above toward the slave; out_aw_id, out_ar_id, out_b_id, out_r_id are OUT_ID_W
busy  out  1  any slot in either table allocated

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Structure: two independent tables, write (AW alloc / B release) and read (AR alloc / R-last release). Each slot holds valid, in_id[IN_ID_W], cnt.
- Allocation (combinational lookup each cycle):
  - hit = a valid slot whose in_id equals the request id. Use that slot; this preserves same-ID ordering.
  - Else pick the lowest-index invalid slot.
  - Hit with cnt == MAX_OUT, or miss with no free slot: blocked.
- Request path:
  - out_ax_valid = in_ax_valid & !blocked.
  - in_ax_ready = out_ax_ready & !blocked.
  - out_ax_id = chosen slot; payload unchanged.
  - Zero added latency.
- Update on out handshake: slot.valid <= 1, slot.in_id <= id, cnt++.
- Release:
  - B handshake, or R handshake with last=1: cnt-- on slot out_*_id.
  - Slot valid clears when cnt reaches 0.
  - R beats without last do not touch the table.
- Response path: in_resp_id = table[out_resp_id].in_id; valid, ready, and payload are combinational pass-through.
- Simultaneous allocation and release on the same slot in one cycle: cnt unchanged, valid stays 1.
- Release of a slot at cnt=1 in the same cycle as an allocation for a different id: the freed slot is not visible to that allocation until the next cycle.
- Protocol error (release of a slot with cnt=0): cnt stays 0, response still forwarded with the stored in_id, no assertion in synthesis.
- W channel: untouched. W ordering follows AW order, which the remapper does not reorder.
- Reset:
  - All valid bits and counts go to 0; busy=0.
  - All in_*_ready and out_*_valid follow their combinational equations, so they are 0 unless the opposite side drives valid/ready.
  - Reset mid-operation drops in-flight state; late responses fall under the protocol-error rule.
- busy = OR of all slot valids (registered state, no combinational input path).

Optional Feature:
- Macro: AXI4_ID_REMAPPER_PERF_EN.
- With the macro defined, add ports:
  - aw_stall_cnt  out  32: saturating count of cycles with in_aw_valid & blocked.
  - ar_stall_cnt  out  32: same for AR.
  - Both cleared by reset.
- Without the macro, these ports and counters do not exist. Functional behaviour is identical either way.

Decomposition:
- Package axi4_id_remapper_pkg: NSLOT/counter-width functions and the slot struct typedef {valid, in_id, cnt}.
- One natural sub-module, axi4_id_remap_table: lookup/alloc/release for one direction, instantiated twice (write and read).

Test Plan:
1. Four AR ids 0x11, 0x22, 0x33, 0x44 back-to-back, slave ready → out ids 0, 1, 2, 3. A fifth AR id 0x55 is stalled (in_ar_ready=0) until the R last for slot 0 arrives; 0x55 then gets out id 0.
2. Same id 0xA7 issued 9 times with MAX_OUT=8 → all 8 use the same slot; the 9th is stalled until one B returns.
3. R burst len=3 on slot 2 holding 0x33 → 4 beats return in_r_id=0x33; the slot frees only after the last beat.
4. AW alloc for 0x10 and B release of the slot at cnt=1 in the same cycle, same id → cnt stays 1 and the slot stays valid.
5. Reset asserted with 3 outstanding reads → busy=0 next cycle; a new AR id 0x99 gets out id 0.
6. PERF_EN: hold in_aw_valid blocked for 10 cycles → aw_stall_cnt=10.
